// File: rtl/parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_rx
//  Description : Serial frame receiver and parity checker. Frames are
//                start(0), DW data bits LSB first, parity, stop(1), one bit
//                per bit_en strobe. Delivers the byte plus parity and framing
//                error flags with a one-cycle valid pulse.
//  Options     : PARITY_RX_ERRCNT_EN - adds a saturating 8-bit count of
//                parity-error frames on err_cnt (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_rx #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_en,
  input  logic          rx,
  input  logic          par_odd,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          par_err,
  output logic          frm_err,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    sreg;
  logic             pbit;
  logic             odd_q;
  logic             frame_par_err;

  // Odd scheme flips the expected parity, so XOR-ing odd_q in folds both
  // schemes into a single mismatch term.
  assign frame_par_err = (^sreg) ^ pbit ^ odd_q;
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; only strobe cycles advance the FSM.
  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      case (state)
        IDLE: if (!rx) state_nxt = DATA;
        DATA: if (cnt == C_LAST_BIT) state_nxt = PAR;
        PAR:  state_nxt = STOP;
        STOP: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift in data, capture parity, and publish results on the stop strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sreg    <= '0;
      pbit    <= 1'b0;
      odd_q   <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx) begin
              cnt   <= '0;
              odd_q <= par_odd;
            end
          end
          DATA: begin
            sreg <= {rx, sreg[DW-1:1]};
            cnt  <= cnt + 1'b1;
          end
          PAR: begin
            pbit <= rx;
          end
          STOP: begin
            data    <= sreg;
            par_err <= frame_par_err;
            frm_err <= ~rx;
            valid   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PARITY_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating parity-error counter, stepping on the same edge as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (bit_en && (state == STOP) && frame_par_err &&
                 (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire
